// File: rtl/common_pkg.sv
// common_pkg: shared elaboration helpers for parameter
// derivation and checking across the FIFO family.
package common_pkg;

    function automatic int clogb2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic bit show_ahead_legal_f(input string mode);
        return (mode == "ON") || (mode == "OFF");
    endfunction

    function automatic bit show_ahead_on_f(input string mode);
        return mode == "ON";
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// fifo_ram_sdp: simple dual-port RAM, one write port and one
// read port that is either asynchronous or registered.
module fifo_ram_sdp
    import common_pkg::*;
#(
    parameter int    DEPTH      = 32,
    parameter int    DW         = 32,
    parameter string SHOW_AHEAD = "OFF",
    localparam int   AW         = clogb2_f(DEPTH)
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic          clr_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    if (show_ahead_on_f(SHOW_AHEAD)) begin : g_async
        logic unused_rd_ctrl;
        assign unused_rd_ctrl = ^{re_i, clr_i, arst_n_i};
        assign rdata_o = mem[raddr_i];
    end else begin : g_sync
        logic [DW-1:0] rdata_q;
        // clr_i mirrors the sync output-register reset of block RAMs
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i)  rdata_q <= '0;
            else if (clr_i) rdata_q <= '0;
            else if (re_i)  rdata_q <= mem[raddr_i];
        end
        assign rdata_o = rdata_q;
    end

endmodule

// File: rtl/fifo_sc_flags.sv
// fifo_sc_flags: single-clock FIFO with almost-full/empty levels,
// sync flush and sticky overflow/underflow flags.
module fifo_sc_flags
    import common_pkg::*;
#(
    parameter int    DEPTH      = 32,
    parameter int    DW         = 32,
    parameter string SHOW_AHEAD = "OFF",
    parameter int    AFULL_LVL  = DEPTH - 2,
    parameter int    AEMPTY_LVL = 2,
    localparam int   AW         = clogb2_f(DEPTH)
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  logic          req_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          afull_o,
    output logic          aempty_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_LVL);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sc_flags: DEPTH must be a power of 2 >= 2");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("fifo_sc_flags: AFULL_LVL out of range 1..DEPTH");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sc_flags: AEMPTY_LVL out of range 0..DEPTH-1");
    end
    if (!show_ahead_legal_f(SHOW_AHEAD)) begin : g_bad_mode
        $error("fifo_sc_flags: SHOW_AHEAD must be ON or OFF");
    end

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_en;
    logic          rd_en;
    logic          ovf_q;
    logic          unf_q;
    logic [DW-1:0] rdata;

    assign count_o     = wr_ptr - rd_ptr;
    assign full_o      = count_o == DEPTH_C;
    assign empty_o     = wr_ptr == rd_ptr;
    assign afull_o     = count_o >= AFULL_C;
    assign aempty_o    = count_o <= AEMPTY_C;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    // flush masks both enables so it wins over any access
    assign wr_en = valid_i & ~full_o & ~flush_i;
    assign rd_en = req_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            if (valid_i & full_o) ovf_q <= 1'b1;
            if (req_i & empty_o)  unf_q <= 1'b1;
        end
    end

    fifo_ram_sdp #(
        .DEPTH      (DEPTH),
        .DW         (DW),
        .SHOW_AHEAD (SHOW_AHEAD)
    ) u_ram (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .we_i     (wr_en),
        .waddr_i  (wr_ptr[AW-1:0]),
        .wdata_i  (data_i),
        .re_i     (rd_en),
        .clr_i    (flush_i),
        .raddr_i  (rd_ptr[AW-1:0]),
        .rdata_o  (rdata)
    );

    assign data_o = rdata;

    if (show_ahead_on_f(SHOW_AHEAD)) begin : g_fwft
        assign valid_o = ~empty_o;
    end else begin : g_reg
        logic valid_q;
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i)    valid_q <= 1'b0;
            else if (flush_i) valid_q <= 1'b0;
            else              valid_q <= rd_en;
        end
        assign valid_o = valid_q;
    end

endmodule

// File: tb/tb_fifo_sc_flags.sv
// tb_fifo_sc_flags: checks registered and show-ahead FIFOs
// against a queue model, a vector table and corner sequences.
module tb_fifo_sc_flags;

    localparam int D  = 8;
    localparam int AF = D - 2;
    localparam int AE = 2;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic flush = 1'b0;
    logic valid = 1'b0;
    logic [7:0] data = '0;
    logic req = 1'b0;

    logic [7:0] do_off, do_on;
    logic vo_off, vo_on;
    logic full_off, full_on, empty_off, empty_on;
    logic afull_off, afull_on, aempty_off, aempty_on;
    logic ovf_off, ovf_on, unf_off, unf_on;
    logic [3:0] cnt_off, cnt_on;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_sc_flags #(.DEPTH(D), .DW(8), .SHOW_AHEAD("OFF")) u_off (
        .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush),
        .valid_i(valid), .data_i(data), .req_i(req),
        .data_o(do_off), .valid_o(vo_off), .full_o(full_off),
        .empty_o(empty_off), .afull_o(afull_off), .aempty_o(aempty_off),
        .count_o(cnt_off), .overflow_o(ovf_off), .underflow_o(unf_off)
    );

    fifo_sc_flags #(.DEPTH(D), .DW(8), .SHOW_AHEAD("ON")) u_on (
        .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush),
        .valid_i(valid), .data_i(data), .req_i(req),
        .data_o(do_on), .valid_o(vo_on), .full_o(full_on),
        .empty_o(empty_on), .afull_o(afull_on), .aempty_o(aempty_on),
        .count_o(cnt_on), .overflow_o(ovf_on), .underflow_o(unf_on)
    );

    // behavioural model: contents as a queue plus sticky flags
    logic [7:0] q[$];
    bit m_ovf, m_unf, m_voff;
    logic [7:0] m_doff;

    function automatic void model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_voff = 0;
        m_doff = '0;
    endfunction

    function automatic void model_step(bit f, bit v, logic [7:0] d, bit r);
        int n = q.size();
        if (f) begin
            model_reset();
            return;
        end
        if (v && n == D) m_ovf = 1;
        if (r && n == 0) m_unf = 1;
        m_voff = 0;
        if (r && n > 0) begin
            m_doff = q.pop_front();
            m_voff = 1;
        end
        if (v && n < D) q.push_back(d);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        logic [5:0] ef;
        ef = {n == D, n == 0, n >= AF, n <= AE, m_ovf, m_unf};
        chk("off.count", 32'(cnt_off), n);
        chk("on.count", 32'(cnt_on), n);
        chk("off.flags", {full_off, empty_off, afull_off, aempty_off, ovf_off, unf_off}, ef);
        chk("on.flags", {full_on, empty_on, afull_on, aempty_on, ovf_on, unf_on}, ef);
        chk("off.valid", vo_off, m_voff);
        chk("off.data", do_off, m_doff);
        chk("on.valid", vo_on, n != 0);
        if (n != 0) chk("on.data", do_on, q[0]);
    endtask

    task automatic step(bit f, bit v, logic [7:0] d, bit r);
        @(negedge clk);
        flush = f;
        valid = v;
        data = d;
        req = r;
        @(posedge clk);
        model_step(f, v, d, r);
        #1 check_all();
    endtask

    typedef struct {
        bit f, v, r;
        logic [7:0] d;
        int cnt;
        bit full, empty, afull, aempty, ovf, unf, voff;
        logic [7:0] doff;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_row(bit f, bit v, bit r, logic [7:0] d, int cnt,
                                    bit ovf, bit unf, bit voff, logic [7:0] doff);
        vec_t t;
        t.f = f; t.v = v; t.r = r; t.d = d; t.cnt = cnt;
        t.full = cnt == 8;
        t.empty = cnt == 0;
        t.afull = cnt >= 6;
        t.aempty = cnt <= 2;
        t.ovf = ovf; t.unf = unf; t.voff = voff; t.doff = doff;
        tbl.push_back(t);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int pw;
        model_reset();

        // fill, overflow, drain, underflow, flush
        for (int i = 0; i < 8; i++) add_row(0, 1, 0, 8'(8'h11 + i), i + 1, 0, 0, 0, 8'h00);
        add_row(0, 1, 0, 8'hFF, 8, 1, 0, 0, 8'h00);
        for (int k = 0; k < 8; k++) add_row(0, 0, 1, 8'h00, 7 - k, 1, 0, 1, 8'(8'h11 + k));
        add_row(0, 0, 1, 8'h00, 0, 1, 1, 0, 8'h18);
        add_row(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);

        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk);
        arst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
            chk("tbl.count", 32'(cnt_off), tbl[i].cnt);
            chk("tbl.flags", {full_off, empty_off, afull_off, aempty_off, ovf_off, unf_off},
                {tbl[i].full, tbl[i].empty, tbl[i].afull, tbl[i].aempty, tbl[i].ovf, tbl[i].unf});
            chk("tbl.valid", vo_off, tbl[i].voff);
            chk("tbl.data", do_off, tbl[i].doff);
        end

        // show-ahead: a word written to an empty FIFO is visible next cycle
        step(0, 1, 8'hA5, 0);
        chk("sa.valid", vo_on, 1);
        chk("sa.data", do_on, 8'hA5);
        step(0, 0, 8'h00, 1);
        chk("sa.empty", empty_on, 1);
        chk("sa.validlo", vo_on, 0);

        // sustained push+pop at count 4 across several pointer wraps
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h20 + i), 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 8'(8'h30 + i), 1);
            chk("thru.count", 32'(cnt_on), 4);
        end
        step(1, 0, 8'h00, 0);

        // async reset while half full and mid-burst
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h50 + i), 0);
        @(negedge clk);
        valid = 1'b1;
        data = 8'h60;
        req = 1'b1;
        #2 arst_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("rst.empty", empty_off, 1);
        @(negedge clk);
        valid = 1'b0;
        req = 1'b0;
        arst_n = 1'b1;
        step(0, 1, 8'h77, 0);
        step(0, 1, 8'h78, 0);
        step(0, 0, 8'h00, 1);
        chk("rst.first", do_off, 8'h77);

        // randomized traffic with fill/drain bias phases
        pw = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pw = 20 + 30 * $urandom_range(0, 2);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < pw,
                 8'($urandom),
                 $urandom_range(0, 99) < (100 - pw));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
